// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and default parameters for the step sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } transport_state_t;

  localparam logic PITCH_REST = 1'b0;

  localparam int DEF_NUM_STEPS      = 16;
  localparam int DEF_NUM_TRACKS     = 2;
  localparam int DEF_PITCH_W        = 4;
  localparam int DEF_CLK_FREQ       = 12_000_000;
  localparam int DEF_STEPS_PER_BEAT = 4;
  localparam int DEF_BPM_MIN        = 40;
  localparam int DEF_BPM_MAX        = 240;
  localparam int DEF_BPM_DEFAULT    = 120;
  localparam int DEF_BPM_STEP       = 4;

endpackage

// File: rtl/tempo_gen.sv
// rtl/tempo_gen.sv - bpm register and phase accumulator producing step ticks
module tempo_gen
  import seq_pkg::*;
#(
  parameter int CLK_FREQ       = DEF_CLK_FREQ,
  parameter int STEPS_PER_BEAT = DEF_STEPS_PER_BEAT,
  parameter int BPM_MIN        = DEF_BPM_MIN,
  parameter int BPM_MAX        = DEF_BPM_MAX,
  parameter int BPM_DEFAULT    = DEF_BPM_DEFAULT,
  parameter int BPM_STEP       = DEF_BPM_STEP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic       tempo_up,
  input  logic       tempo_down,
  output logic       tick,
  output logic [7:0] bpm
);

  localparam int LIMIT_I = CLK_FREQ * 60;
  localparam int ACC_W   = $clog2(LIMIT_I + BPM_MAX * STEPS_PER_BEAT);
  localparam int SUM_W   = ACC_W + 1;
  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(LIMIT_I);

  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] inc;
  logic [SUM_W-1:0] sum;
  logic [8:0]       bpm_up;

  assign inc    = SUM_W'(bpm) * SUM_W'(STEPS_PER_BEAT);
  assign sum    = SUM_W'(acc) + inc;
  assign tick   = run && !clear && (sum >= LIMIT);
  assign bpm_up = {1'b0, bpm} + 9'(BPM_STEP);

  // The remainder is carried across ticks so the step rate never drifts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (run) begin
      acc <= tick ? ACC_W'(sum - LIMIT) : ACC_W'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bpm <= 8'(BPM_DEFAULT);
    end else if (tempo_up && !tempo_down) begin
      bpm <= (bpm_up >= 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpm_up[7:0];
    end else if (tempo_down && !tempo_up) begin
      bpm <= ({1'b0, bpm} <= 9'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN) : bpm - 8'(BPM_STEP);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - multi-track pitch step sequencer with transport and tempo control
module step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STEPS      = DEF_NUM_STEPS,
  parameter int NUM_TRACKS     = DEF_NUM_TRACKS,
  parameter int PITCH_W        = DEF_PITCH_W,
  parameter int CLK_FREQ       = DEF_CLK_FREQ,
  parameter int STEPS_PER_BEAT = DEF_STEPS_PER_BEAT,
  parameter int BPM_MIN        = DEF_BPM_MIN,
  parameter int BPM_MAX        = DEF_BPM_MAX,
  parameter int BPM_DEFAULT    = DEF_BPM_DEFAULT,
  parameter int BPM_STEP       = DEF_BPM_STEP,
  localparam int SW            = $clog2(NUM_STEPS),
  localparam int TW            = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          edit_valid,
  input  logic [TW-1:0]                 edit_track,
  input  logic [SW-1:0]                 edit_step,
  input  logic [PITCH_W-1:0]            edit_pitch,
  input  logic                          clear_all,
  input  logic                          play_toggle,
  input  logic                          stop,
  input  logic                          tempo_up,
  input  logic                          tempo_down,
  output logic [SW-1:0]                 step_idx,
  output logic [NUM_TRACKS*PITCH_W-1:0] pitch_out,
  output logic [NUM_TRACKS-1:0]         note_on,
  output logic                          playing,
  output logic [7:0]                    bpm
);

  transport_state_t state, state_nxt;

  logic [PITCH_W-1:0] mem     [NUM_TRACKS][NUM_STEPS];
  logic [PITCH_W-1:0] mem_nxt [NUM_TRACKS][NUM_STEPS];

  logic                          tick, run, start, acc_clear, note_evt, edit_hit;
  logic [SW-1:0]                 step_nxt;
  logic [NUM_TRACKS*PITCH_W-1:0] pitch_nxt;
  logic [NUM_TRACKS-1:0]         note_nxt;

  tempo_gen #(
    .CLK_FREQ      (CLK_FREQ),
    .STEPS_PER_BEAT(STEPS_PER_BEAT),
    .BPM_MIN       (BPM_MIN),
    .BPM_MAX       (BPM_MAX),
    .BPM_DEFAULT   (BPM_DEFAULT),
    .BPM_STEP      (BPM_STEP)
  ) u_tempo (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clear     (acc_clear),
    .tempo_up  (tempo_up),
    .tempo_down(tempo_down),
    .tick      (tick),
    .bpm       (bpm)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (play_toggle) begin
      case (state)
        RUN:     state_nxt = PAUSE;
        default: state_nxt = RUN;
      endcase
    end
  end

  // A fresh start plays step 0 at once; resuming from pause waits for the accumulator.
  always_comb begin
    run       = (state == RUN);
    start     = (state == IDLE) && play_toggle && !stop;
    acc_clear = stop || start;
    note_evt  = start || tick;
    step_nxt  = step_idx;
    if (stop || start) begin
      step_nxt = '0;
    end else if (tick) begin
      step_nxt = (step_idx == SW'(NUM_STEPS - 1)) ? '0 : step_idx + 1'b1;
    end
  end

  assign edit_hit = edit_valid && (32'(edit_track) < $unsigned(NUM_TRACKS))
                               && (32'(edit_step) < $unsigned(NUM_STEPS));

  always_comb begin
    mem_nxt = mem;
    if (clear_all) begin
      for (int t = 0; t < NUM_TRACKS; t++)
        for (int s = 0; s < NUM_STEPS; s++)
          mem_nxt[t][s] = '0;
    end else if (edit_hit) begin
      mem_nxt[edit_track][edit_step] = edit_pitch;
    end
  end

  // Outputs read the post-edit storage so a same-cycle edit wins over the old pitch.
  always_comb begin
    pitch_nxt = '0;
    note_nxt  = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      pitch_nxt[t*PITCH_W +: PITCH_W] = mem_nxt[t][step_nxt];
      note_nxt[t] = note_evt && (mem_nxt[t][step_nxt] != PITCH_W'(PITCH_REST));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TRACKS; t++)
        for (int s = 0; s < NUM_STEPS; s++)
          mem[t][s] <= '0;
    end else begin
      mem <= mem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_idx  <= '0;
      pitch_out <= '0;
      note_on   <= '0;
      playing   <= 1'b0;
    end else begin
      step_idx  <= step_nxt;
      pitch_out <= pitch_nxt;
      note_on   <= note_nxt;
      playing   <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer with a behavioural model
module tb_step_sequencer;

  localparam int NS    = 16;
  localparam int NT    = 2;
  localparam int LIMIT = 1000 * 60;

  logic       clk = 1'b0;
  logic       rst, edit_valid, clear_all, play_toggle, stop, tempo_up, tempo_down;
  logic [0:0] edit_track;
  logic [3:0] edit_step, edit_pitch, step_idx;
  logic [7:0] pitch_out, bpm;
  logic [1:0] note_on;
  logic       playing;

  int n_checks = 0;
  int n_pass   = 0;

  int     m_state;
  int     m_step;
  int     m_bpm;
  longint m_units;
  longint m_ticks;
  int     m_mem [NT][NS];
  int     e_pitch;
  int     e_note;

  always #5 clk = ~clk;

  step_sequencer #(
    .NUM_STEPS     (NS),
    .NUM_TRACKS    (NT),
    .PITCH_W       (4),
    .CLK_FREQ      (1000),
    .STEPS_PER_BEAT(4),
    .BPM_MIN       (40),
    .BPM_MAX       (240),
    .BPM_DEFAULT   (150),
    .BPM_STEP      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .edit_valid (edit_valid),
    .edit_track (edit_track),
    .edit_step  (edit_step),
    .edit_pitch (edit_pitch),
    .clear_all  (clear_all),
    .play_toggle(play_toggle),
    .stop       (stop),
    .tempo_up   (tempo_up),
    .tempo_down (tempo_down),
    .step_idx   (step_idx),
    .pitch_out  (pitch_out),
    .note_on    (note_on),
    .playing    (playing),
    .bpm        (bpm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Tempo modelled as total accumulated work: a step is due whenever work/LIMIT exceeds steps taken.
  function automatic void model_update();
    bit ev = 1'b0;
    if (rst) begin
      m_state = 0; m_step = 0; m_units = 0; m_ticks = 0; m_bpm = 150;
      foreach (m_mem[t, s]) m_mem[t][s] = 0;
    end else begin
      if (clear_all) foreach (m_mem[t, s]) m_mem[t][s] = 0;
      else if (edit_valid && int'(edit_track) < NT && int'(edit_step) < NS)
        m_mem[edit_track][edit_step] = int'(edit_pitch);
      if (stop) begin
        m_state = 0; m_step = 0; m_units = 0; m_ticks = 0;
      end else if (m_state == 0 && play_toggle) begin
        m_state = 1; m_step = 0; m_units = 0; m_ticks = 0; ev = 1'b1;
      end else begin
        if (m_state == 1) begin
          m_units += m_bpm * 4;
          if (m_units / LIMIT > m_ticks) begin
            m_ticks++;
            m_step = (m_step + 1) % NS;
            ev = 1'b1;
          end
        end
        if (play_toggle) m_state = (m_state == 1) ? 2 : 1;
      end
      if (tempo_up && !tempo_down)      m_bpm = (m_bpm + 4 > 240) ? 240 : m_bpm + 4;
      else if (tempo_down && !tempo_up) m_bpm = (m_bpm - 4 < 40) ? 40 : m_bpm - 4;
    end
    e_pitch = m_mem[1][m_step] * 16 + m_mem[0][m_step];
    e_note  = ((ev && m_mem[1][m_step] != 0) ? 2 : 0) + ((ev && m_mem[0][m_step] != 0) ? 1 : 0);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check("step_idx", step_idx, m_step);
    check("pitch_out", pitch_out, e_pitch);
    check("note_on", note_on, e_note);
    check("playing", playing, (m_state == 1) ? 1 : 0);
    check("bpm", bpm, m_bpm);
    rst = 0; edit_valid = 0; clear_all = 0; play_toggle = 0;
    stop = 0; tempo_up = 0; tempo_down = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic edit_cyc(input int t, input int s, input int p);
    edit_valid = 1; edit_track = 1'(t); edit_step = 4'(s); edit_pitch = 4'(p);
    cycle();
  endtask

  initial begin
    rst = 1; edit_valid = 0; clear_all = 0; play_toggle = 0; stop = 0;
    tempo_up = 0; tempo_down = 0; edit_track = 0; edit_step = 0; edit_pitch = 0;

    repeat (3) begin rst = 1; cycle(); end
    check("rst_step", step_idx, 0);
    check("rst_pitch", pitch_out, 0);
    check("rst_note", note_on, 0);
    check("rst_playing", playing, 0);
    check("rst_bpm", bpm, 150);
    cycle();

    edit_cyc(0, 0, 5);
    edit_cyc(0, 2, 9);
    play_toggle = 1; cycle();
    check("start_note", note_on[0], 1);
    check("start_pitch", pitch_out[3:0], 5);
    run(99);  check("pre_step1", step_idx, 0);
    cycle();  check("step1", step_idx, 1); check("step1_note", note_on, 0);
    run(99);  cycle();
    check("step2", step_idx, 2); check("step2_note", note_on[0], 1);
    check("step2_pitch", pitch_out[3:0], 9);
    run(1399); check("step15", step_idx, 15);
    cycle();   check("wrap", step_idx, 0); check("wrap_note", note_on[0], 1);

    stop = 1; cycle();
    play_toggle = 1; cycle();
    run(249);
    play_toggle = 1; cycle();
    check("pause_playing", playing, 0); check("pause_step", step_idx, 2);
    run(500); check("pause_hold", step_idx, 2);
    play_toggle = 1; cycle();
    run(49);  check("resume_pre", step_idx, 2);
    cycle();  check("resume_step3", step_idx, 3); check("resume_playing", playing, 1);
    stop = 1; cycle();
    check("stop_step", step_idx, 0); check("stop_playing", playing, 0);

    repeat (30) begin tempo_up = 1; cycle(); end
    check("bpm_max", bpm, 240);
    repeat (60) begin tempo_down = 1; cycle(); end
    check("bpm_min", bpm, 40);
    tempo_up = 1; tempo_down = 1; cycle();
    check("bpm_both", bpm, 40);
    repeat (40) begin tempo_up = 1; cycle(); end
    check("bpm_200", bpm, 200);
    play_toggle = 1; cycle();
    run(74); check("t200_pre", step_idx, 0);
    cycle(); check("t200_step1", step_idx, 1);

    run(224);
    edit_cyc(1, 4, 7);
    check("coll_step", step_idx, 4);
    check("coll_pitch", pitch_out[7:4], 7);
    check("coll_note", note_on[1], 1);

    clear_all = 1; edit_valid = 1; edit_track = 0; edit_step = 4; edit_pitch = 3;
    cycle();
    check("clear_pitch", pitch_out, 0);
    edit_cyc(0, 5, 6);
    run(72);
    rst = 1; cycle();
    check("rst_run_note", note_on, 0);
    check("rst_run_playing", playing, 0);
    check("rst_run_step", step_idx, 0);
    check("rst_run_bpm", bpm, 150);

    repeat (3000) begin
      edit_valid  = ($urandom_range(0, 99) < 20);
      edit_track  = 1'($urandom);
      edit_step   = 4'($urandom);
      edit_pitch  = 4'($urandom);
      clear_all   = ($urandom_range(0, 199) == 0);
      play_toggle = ($urandom_range(0, 49) == 0);
      stop        = ($urandom_range(0, 299) == 0);
      tempo_up    = ($urandom_range(0, 29) == 0);
      tempo_down  = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
